// File: rtl/char_pattern_gen.sv
// ---------------------------------------------------------------------------
// char_pattern_gen
//
// Produces a continuous printable-ASCII test pattern for a UART transmitter.
// Each line is LINE_LEN printable characters from the range FIRST_CHAR..
// LAST_CHAR (wrapping), optionally followed by CR or CR+LF. In ROLL mode
// every line starts one character later than the previous one, which gives
// the classic "barber-pole" look on a terminal. An optional line limit stops
// the generator and raises a sticky done flag.
//
// Ports:
//   clock      - system clock, all logic on posedge
//   reset      - synchronous, active-high
//   enable     - allow generation of new characters
//   out_ready  - downstream can accept a character this cycle
//   out_valid  - out_data holds a character
//   out_data   - character, zero-extended to DATA_W bits
//   col        - column of the current printable character (0..LINE_LEN-1)
//   line_cnt   - number of completed lines (wraps at 2^16)
//   line_done  - one-cycle pulse after the last character of a line is taken
//   done       - sticky, MAX_LINES lines have been completed
// ---------------------------------------------------------------------------
module char_pattern_gen #(
    parameter int         DATA_W     = 12,
    parameter int         LINE_LEN   = 80,
    parameter logic [6:0] FIRST_CHAR = 7'o040,
    parameter logic [6:0] LAST_CHAR  = 7'o176,
    parameter int         EOL_MODE   = 2,
    parameter int         ROLL       = 1,
    parameter int         MAX_LINES  = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [6:0]        col,
    output logic [15:0]       line_cnt,
    output logic              line_done,
    output logic              done
);

    localparam logic [6:0]  LAST_COL    = 7'(LINE_LEN - 1);
    localparam logic [15:0] LINE_LIMIT  = 16'(MAX_LINES);
    localparam logic [6:0]  CR_CHAR     = 7'o015;
    localparam logic [6:0]  LF_CHAR     = 7'o012;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHAR,
        S_CR,
        S_LF,
        S_DONE
    } state_t;

    state_t      state_reg;
    // Which part of the line comes next (CHAR, CR or LF). Kept separately
    // from state_reg so that pausing in IDLE does not lose the EOL phase.
    state_t      phase_reg;
    logic [6:0]  ch_reg;
    logic [6:0]  line_start_reg;
    logic [6:0]  col_reg;
    logic [15:0] line_cnt_reg;

    // Position after accepting the character currently on the output
    state_t      phase_next;
    logic [6:0]  ch_next;
    logic [6:0]  line_start_next;
    logic [6:0]  col_next;
    logic [15:0] line_cnt_next;
    logic        new_line;
    logic        limit_hit;
    logic        accept;

    function automatic logic [6:0] wrap(input logic [6:0] x);
        return (x == LAST_CHAR) ? FIRST_CHAR : x + 7'd1;
    endfunction

    function automatic logic [DATA_W-1:0] char_for(input state_t phase,
                                                    input logic [6:0] c);
        logic [6:0] sel;
        case (phase)
            S_CR:    sel = CR_CHAR;
            S_LF:    sel = LF_CHAR;
            default: sel = c;
        endcase
        return DATA_W'(sel);
    endfunction

    assign accept = out_valid & out_ready;

    always_comb begin
        phase_next      = phase_reg;
        ch_next         = ch_reg;
        line_start_next = line_start_reg;
        col_next        = col_reg;
        line_cnt_next   = line_cnt_reg;
        new_line        = 1'b0;

        case (state_reg)
            S_CHAR: begin
                if (col_reg < LAST_COL) begin
                    col_next = col_reg + 7'd1;
                    ch_next  = wrap(ch_reg);
                end else if (EOL_MODE >= 1) begin
                    phase_next = S_CR;
                end else begin
                    new_line = 1'b1;
                end
            end
            S_CR: begin
                if (EOL_MODE == 2) begin
                    phase_next = S_LF;
                end else begin
                    new_line = 1'b1;
                end
            end
            S_LF: begin
                new_line = 1'b1;
            end
            default: begin
            end
        endcase

        if (new_line) begin
            phase_next      = S_CHAR;
            line_start_next = (ROLL != 0) ? wrap(line_start_reg) : FIRST_CHAR;
            ch_next         = line_start_next;
            col_next        = 7'd0;
            line_cnt_next   = line_cnt_reg + 16'd1;
        end

        limit_hit = new_line && (MAX_LINES != 0) && (line_cnt_next == LINE_LIMIT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            phase_reg      <= S_CHAR;
            ch_reg         <= FIRST_CHAR;
            line_start_reg <= FIRST_CHAR;
            col_reg        <= 7'd0;
            line_cnt_reg   <= 16'd0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            line_done      <= 1'b0;
            done           <= 1'b0;
        end else begin
            line_done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (enable) begin
                        out_valid <= 1'b1;
                        out_data  <= char_for(phase_reg, ch_reg);
                        state_reg <= phase_reg;
                    end
                end
                S_CHAR, S_CR, S_LF: begin
                    // Without an accept everything holds, so a pending
                    // character stays stable even if enable falls.
                    if (accept) begin
                        phase_reg      <= phase_next;
                        ch_reg         <= ch_next;
                        line_start_reg <= line_start_next;
                        col_reg        <= col_next;
                        line_cnt_reg   <= line_cnt_next;
                        line_done      <= new_line;
                        if (limit_hit) begin
                            state_reg <= S_DONE;
                            done      <= 1'b1;
                            out_valid <= 1'b0;
                        end else if (enable) begin
                            state_reg <= phase_next;
                            out_data  <= char_for(phase_next, ch_next);
                        end else begin
                            state_reg <= S_IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    out_valid <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign col      = col_reg;
    assign line_cnt = line_cnt_reg;

endmodule

// File: tb/tb_char_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_char_pattern_gen
//
// Directed bench for char_pattern_gen. Instance A uses the default
// parameters (80 columns, CR+LF, rolling start); instance B uses a short
// 4-column CR-only line with a two-line limit. Expected characters for A
// come from a closed-form description of the pattern: accepted character n
// lies in line n/82 at position n%82; positions 80 and 81 are CR and LF,
// otherwise the character is 040 + ((line + pos) mod 95).
// ---------------------------------------------------------------------------
module tb_char_pattern_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults
    logic        a_rst, a_en, a_rdy;
    logic        a_valid, a_ld, a_done;
    logic [11:0] a_data;
    logic [6:0]  a_col;
    logic [15:0] a_lcnt;

    // Instance B: LINE_LEN=4, CR only, no roll, two lines
    logic        b_rst, b_en, b_rdy;
    logic        b_valid, b_ld, b_done;
    logic [11:0] b_data;
    logic [6:0]  b_col;
    logic [15:0] b_lcnt;

    char_pattern_gen dut_a (
        .clock     (clk),
        .reset     (a_rst),
        .enable    (a_en),
        .out_ready (a_rdy),
        .out_valid (a_valid),
        .out_data  (a_data),
        .col       (a_col),
        .line_cnt  (a_lcnt),
        .line_done (a_ld),
        .done      (a_done)
    );

    char_pattern_gen #(
        .LINE_LEN  (4),
        .EOL_MODE  (1),
        .ROLL      (0),
        .MAX_LINES (2)
    ) dut_b (
        .clock     (clk),
        .reset     (b_rst),
        .enable    (b_en),
        .out_ready (b_rdy),
        .out_valid (b_valid),
        .out_data  (b_data),
        .col       (b_col),
        .line_cnt  (b_lcnt),
        .line_done (b_ld),
        .done      (b_done)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] exp_a(input int n);
        int line;
        int pos;
        line = n / 82;
        pos  = n % 82;
        if (pos == 80) return 7'o015;
        if (pos == 81) return 7'o012;
        return 7'(32 + ((line + pos) % 95));
    endfunction

    function automatic int exp_col(input int n);
        int pos;
        pos = n % 82;
        return (pos < 80) ? pos : 79;
    endfunction

    int          acc;
    logic        prev_pend;
    logic [11:0] prev_data;
    logic        found;
    logic [6:0]  b_tab [10];

    initial begin
        b_tab = '{7'o040, 7'o041, 7'o042, 7'o043, 7'o015,
                  7'o040, 7'o041, 7'o042, 7'o043, 7'o015};
        a_rst = 1'b1; a_en = 1'b0; a_rdy = 1'b0;
        b_rst = 1'b1; b_en = 1'b0; b_rdy = 1'b0;
        step();
        step();

        // Reset state
        check("rst_valid",     a_valid, 0);
        check("rst_data",      a_data,  0);
        check("rst_col",       a_col,   0);
        check("rst_line_cnt",  a_lcnt,  0);
        check("rst_line_done", a_ld,    0);
        check("rst_done",      a_done,  0);
        $display("reset: valid=%0d data=%0o col=%0d line_cnt=%0d", a_valid, a_data, a_col, a_lcnt);

        a_rst = 1'b0;
        step();
        check("idle_no_enable", a_valid, 0);

        // One cycle from enable to first valid
        a_en = 1'b1; a_rdy = 1'b1;
        step();
        check("first_latency", a_valid, 1);

        // Back-to-back for 95 full lines plus the first char of line 96
        acc = 0;
        for (int cyc = 0; cyc < 7791; cyc++) begin
            check("b2b_valid", a_valid, 1);
            check("b2b_data",  a_data,  exp_a(acc));
            check("b2b_col",   a_col,   exp_col(acc));
            case (acc)
                0:    check("char1_040",      a_data, 7'o040);
                1:    check("char2_041",      a_data, 7'o041);
                2:    check("char3_042",      a_data, 7'o042);
                79:   begin
                          check("char80_157", a_data, 7'o157);
                          check("char80_col", a_col,  79);
                      end
                80:   check("eol_cr",         a_data, 7'o015);
                81:   check("eol_lf",         a_data, 7'o012);
                82:   check("line2_start",    a_data, 7'o041);
                7708: check("line95_start",   a_data, 7'o176);
                7709: check("line95_wrap",    a_data, 7'o040);
                7790: check("line96_start",   a_data, 7'o040);
                default: ;
            endcase
            if (acc % 82 == 0)
                $display("line %0d start: data=%0o col=%0d", acc / 82 + 1, a_data, a_col);
            step();
            check("b2b_line_done", a_ld, (acc % 82 == 81));
            if (acc % 82 == 81)
                check("b2b_line_cnt", a_lcnt, 16'(acc / 82 + 1));
            acc++;
        end

        // Random back-pressure: held data stable, same sequence accepted
        prev_pend = 1'b0;
        prev_data = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            check("rand_valid", a_valid, 1);
            if (prev_pend)
                check("rand_hold", a_data, prev_data);
            a_rdy = 1'($urandom_range(0, 1));
            if (a_rdy) begin
                check("rand_data", a_data, exp_a(acc));
                acc++;
            end
            prev_pend = !a_rdy;
            prev_data = a_data;
            step();
        end
        a_rdy = 1'b1;
        $display("random ready: %0d characters accepted in total", acc);

        // Drop enable while the col 40 character is pending
        found = 1'b0;
        for (int cyc = 0; cyc < 200 && !found; cyc++) begin
            if (a_valid && a_col == 7'd40) begin
                found = 1'b1;
            end else begin
                if (a_valid) acc++;
                step();
            end
        end
        check("col40_reached", found, 1);
        check("col40_data", a_data, exp_a(acc));
        a_en = 1'b0;
        step();
        acc++;
        check("drop_valid_low", a_valid, 0);
        check("drop_col_41",    a_col,   41);
        step();
        step();
        check("paused_valid", a_valid, 0);
        a_en = 1'b1;
        step();
        check("resume_valid", a_valid, 1);
        check("resume_data",  a_data,  exp_a(acc));
        check("resume_col",   a_col,   41);
        $display("resume: data=%0o col=%0d", a_data, a_col);

        // Restart, then reset during the CR of line 3
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
        check("restart_line_cnt", a_lcnt, 0);
        step();
        acc = 0;
        for (int cyc = 0; cyc < 400 && acc < 244; cyc++) begin
            if (a_valid) acc++;
            step();
        end
        check("l3_cr_data",     a_data, 7'o015);
        check("l3_cr_line_cnt", a_lcnt, 2);
        a_rst = 1'b1;
        step();
        check("mid_rst_valid",     a_valid, 0);
        check("mid_rst_line_cnt",  a_lcnt,  0);
        check("mid_rst_col",       a_col,   0);
        check("mid_rst_data",      a_data,  0);
        check("mid_rst_line_done", a_ld,    0);
        a_rst = 1'b0;
        step();
        check("after_rst_valid", a_valid, 1);
        check("after_rst_data",  a_data,  7'o040);
        check("after_rst_col",   a_col,   0);
        $display("after reset: data=%0o col=%0d", a_data, a_col);

        // Instance B: short lines, CR only, stops after two lines
        b_rst = 1'b0; b_en = 1'b1; b_rdy = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            check("b_valid", b_valid, 1);
            check("b_data",  b_data,  b_tab[i]);
            $display("b char %0d: data=%0o", i, b_data);
            step();
            if (i == 4) begin
                check("b_line1_done", b_ld,   1);
                check("b_line1_cnt",  b_lcnt, 1);
            end
        end
        check("b_done",       b_done,  1);
        check("b_valid_low",  b_valid, 0);
        check("b_line_cnt",   b_lcnt,  2);
        check("b_line2_done", b_ld,    1);
        for (int i = 0; i < 5; i++) step();
        check("b_done_sticky", b_done,  1);
        check("b_done_quiet",  b_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
